// File: rtl/pipe_ctrl.sv
// Lambo registered control unit: decode, LOAD/STORE wait states, halt/start.
// Optional instruction counter enabled by defining LAMBO_CTRL_PERF_EN.

package definitions;

  localparam logic [2:0] _XOR    = 3'd0;
  localparam logic [2:0] _ADD    = 3'd1;
  localparam logic [2:0] _SUB    = 3'd2;
  localparam logic [2:0] _LSHIFT = 3'd3;
  localparam logic [2:0] _CMP    = 3'd4;
  localparam logic [2:0] _BRANCH = 3'd5;
  localparam logic [2:0] _LOAD   = 3'd6;
  localparam logic [2:0] _STORE  = 3'd7;

  typedef struct packed {
    logic imm;
    logic reg_set;
    logic br_en;
    logic cond;
    logic halt;
    logic shift;
    logic rdx;
    logic mem_to_reg;
    logic reg_we;
    logic mem_we;
  } ctrl_t;

endpackage

module pipe_ctrl
  import definitions::*;
#(
  parameter int IW      = 9,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             InstrValid,
  input  logic [IW-1:0]    Instruction,
  input  logic             Flush,
  output logic             Stall,
  output logic             DecValid,
  output logic             Immediate,
  output logic             RegSet,
  output logic             BranchEn,
  output logic             ConditionBranch,
  output logic             Halt,
  output logic             Shift,
  output logic             RDX,
  output logic             MemToReg,
  output logic             RegWriteEn,
  output logic             MemWriteEn,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [1:0] HALTED  = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;

  localparam logic       MULTI = (MEM_LAT > 1);
  localparam logic [3:0] LAT   = 4'(MEM_LAT);

  logic [1:0] state;
  logic [3:0] cnt;
  ctrl_t      ctrl_q;
  logic       dv_q;

  logic [2:0] op;
  logic       c;
  logic [2:0] f;
  logic       s;
  ctrl_t      dec;
  logic       is_mem;
  logic       halt_q;
  logic       cap;

  assign op = Instruction[IW-1 -: 3];
  assign c  = Instruction[IW-4];
  assign f  = Instruction[IW-4 -: 3];
  assign s  = |Instruction[IW-6:0];

  // Combinational decode of the fetched word into control strobes.
  always_comb begin
    dec    = '0;
    is_mem = 1'b0;
    unique case (1'b1)
      (op == _XOR),
      (op == _ADD),
      (op == _SUB): begin
        dec.reg_we = 1'b1;
      end
      (op == _LSHIFT): begin
        dec.imm     = 1'b1;
        dec.reg_we  = 1'b1;
        dec.reg_set = (f == 3'b111);
        dec.rdx     = (f == 3'b110);
      end
      (op == _CMP): begin
        dec.halt  = c & s;
        dec.shift = ~c & s;
      end
      (op == _BRANCH): begin
        dec.br_en = ~s;
      end
      (op == _LOAD): begin
        dec.mem_to_reg = 1'b1;
        dec.reg_we     = ~MULTI;
        is_mem         = 1'b1;
      end
      (op == _STORE): begin
        dec.mem_we = 1'b1;
        is_mem     = 1'b1;
      end
      default: begin
        dec = '0;
      end
    endcase
    dec.cond = c;
  end

  // A halt on the outputs blocks capture; the next edge parks in HALTED.
  assign halt_q = dv_q & ctrl_q.halt;
  assign cap    = (state == RUN) & ~halt_q & InstrValid & ~Flush;

  // Control FSM and registered decode.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= HALTED;
      cnt    <= 4'd0;
      ctrl_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      unique case (state)
        HALTED: begin
          ctrl_q <= '0;
          dv_q   <= 1'b0;
          if (Start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (halt_q) begin
            state  <= HALTED;
            ctrl_q <= '0;
            dv_q   <= 1'b0;
          end else if (cap) begin
            ctrl_q <= dec;
            dv_q   <= 1'b1;
            if (MULTI && is_mem) begin
              state <= MEMWAIT;
              cnt   <= LAT - 4'd1;
            end
          end else begin
            ctrl_q <= '0;
            dv_q   <= 1'b0;
          end
        end
        MEMWAIT: begin
          cnt           <= cnt - 4'd1;
          ctrl_q.mem_we <= 1'b0;
          if (cnt == 4'd1) begin
            state         <= RUN;
            ctrl_q.reg_we <= ctrl_q.mem_to_reg;
          end
        end
        default: begin
          state  <= HALTED;
          ctrl_q <= '0;
          dv_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Stall           = (state != RUN);
  assign Halted          = (state == HALTED);
  assign DecValid        = dv_q;
  assign Immediate       = ctrl_q.imm;
  assign RegSet          = ctrl_q.reg_set;
  assign BranchEn        = ctrl_q.br_en;
  assign ConditionBranch = ctrl_q.cond;
  assign Halt            = ctrl_q.halt;
  assign Shift           = ctrl_q.shift;
  assign RDX             = ctrl_q.rdx;
  assign MemToReg        = ctrl_q.mem_to_reg;
  assign RegWriteEn      = ctrl_q.reg_we;
  assign MemWriteEn      = ctrl_q.mem_we;

`ifdef LAMBO_CTRL_PERF_EN
  logic [CNT_W-1:0] icnt;

  // Saturating count of live captures; cleared when leaving HALTED.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      icnt <= '0;
    end else if ((state == HALTED) && Start) begin
      icnt <= '0;
    end else if (cap && (icnt != '1)) begin
      icnt <= icnt + 1'b1;
    end
  end

  assign InstrCount = icnt;
`else
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MEM_LAT=3, CNT_W=4.
// Expected outputs are queued per step and popped after the edge.

module tb_pipe_ctrl;
  import definitions::*;

`ifdef LAMBO_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [12:0] ST  = 13'h1000;
  localparam logic [12:0] DV  = 13'h0800;
  localparam logic [12:0] IMM = 13'h0400;
  localparam logic [12:0] RS  = 13'h0200;
  localparam logic [12:0] BR  = 13'h0100;
  localparam logic [12:0] CB  = 13'h0080;
  localparam logic [12:0] HT  = 13'h0040;
  localparam logic [12:0] SH  = 13'h0020;
  localparam logic [12:0] RX  = 13'h0010;
  localparam logic [12:0] MTR = 13'h0008;
  localparam logic [12:0] RWE = 13'h0004;
  localparam logic [12:0] MWE = 13'h0002;
  localparam logic [12:0] HD  = 13'h0001;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start;
  logic       InstrValid;
  logic [8:0] Instruction;
  logic       Flush;
  logic       Stall, DecValid, Immediate, RegSet, BranchEn;
  logic       ConditionBranch, Halt, Shift, RDX, MemToReg;
  logic       RegWriteEn, MemWriteEn, Halted;
  logic [3:0] InstrCount;

  always #5 Clk = ~Clk;

  pipe_ctrl #(.IW(9), .MEM_LAT(3), .CNT_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .InstrValid(InstrValid), .Instruction(Instruction),
    .Flush(Flush), .Stall(Stall), .DecValid(DecValid),
    .Immediate(Immediate), .RegSet(RegSet), .BranchEn(BranchEn),
    .ConditionBranch(ConditionBranch), .Halt(Halt),
    .Shift(Shift), .RDX(RDX), .MemToReg(MemToReg),
    .RegWriteEn(RegWriteEn), .MemWriteEn(MemWriteEn),
    .Halted(Halted), .InstrCount(InstrCount)
  );

  typedef struct {
    logic [12:0] v;
    logic [3:0]  c;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [12:0] obs();
    return {Stall, DecValid, Immediate, RegSet, BranchEn,
            ConditionBranch, Halt, Shift, RDX, MemToReg,
            RegWriteEn, MemWriteEn, Halted};
  endfunction

  function automatic logic [3:0] ecnt(input int n);
    return PERF ? 4'(n) : 4'h0;
  endfunction

  function automatic void push(input logic [12:0] v,
                               input int n, input string tag);
    exp_t e;
    e.v = v;
    e.c = ecnt(n);
    e.tag = tag;
    sb.push_back(e);
  endfunction

  task automatic check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    assert ({obs(), InstrCount} === {e.v, e.c}) else begin
      errors++;
      $error("FAIL %s: observed %h cnt %0d, expected %h cnt %0d",
             e.tag, obs(), InstrCount, e.v, e.c);
    end
  endtask

  task automatic step(input logic vld, input logic [8:0] ins,
                      input logic fl, input logic st,
                      input logic [12:0] ev, input int n,
                      input string tag);
    @(negedge Clk);
    InstrValid  = vld;
    Instruction = ins;
    Flush       = fl;
    Start       = st;
    push(ev, n, tag);
    @(posedge Clk);
    #1;
    check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n     = 1'b0;
    Start       = 1'b0;
    InstrValid  = 1'b0;
    Instruction = '0;
    Flush       = 1'b0;
    #2;
    push(ST | HD, 0, "reset");
    check();
    @(negedge Clk);
    Reset_n = 1'b1;

    step(1, {_ADD, 6'b0}, 0, 0, ST | HD, 0, "halted_ignore");
    step(0, '0, 0, 1, '0, 0, "start");
    step(1, {_ADD, 6'b0}, 0, 0, DV | RWE, 1, "add");
    step(1, {_LOAD, 6'b0}, 0, 0, ST | DV | MTR, 2, "load1");
    step(1, {_ADD, 6'b0}, 1, 1, ST | DV | MTR, 2, "load2");
    step(1, {_ADD, 6'b0}, 0, 0, DV | MTR | RWE, 2, "load3");
    step(1, {_STORE, 6'b0}, 0, 0, ST | DV | MWE, 3, "store1");
    step(1, {_ADD, 6'b0}, 1, 0, ST | DV, 3, "store2");
    step(0, '0, 0, 0, DV, 3, "store3");
    step(1, {_BRANCH, 6'b0}, 0, 0, DV | BR, 4, "branch");
    step(1, {_ADD, 6'b0}, 1, 0, '0, 4, "flush");
    step(0, {_ADD, 6'b0}, 0, 0, '0, 4, "invalid");
    step(1, {_LSHIFT, 6'b111000}, 0, 0,
         DV | IMM | RS | CB | RWE, 5, "regset");
    step(1, {_LSHIFT, 6'b110000}, 0, 0,
         DV | IMM | RX | CB | RWE, 6, "rdx");
    step(1, {_CMP, 6'b000001}, 0, 0, DV | SH, 7, "shift");
    step(1, {_CMP, 6'b100001}, 1, 0, '0, 7, "halt_flushed");
    step(1, {_CMP, 6'b100001}, 0, 0, DV | HT | CB, 8, "halt");
    step(1, {_ADD, 6'b0}, 0, 0, ST | HD, 8, "halted");
    step(1, {_ADD, 6'b0}, 0, 0, ST | HD, 8, "halted_hold");
    step(0, '0, 0, 1, '0, 0, "restart");

    for (int i = 1; i <= 20; i++) begin
      step(1, {_ADD, 6'b000011}, 0, 0, DV | RWE,
           (i > 15) ? 15 : i, "sat");
    end

    step(1, {_LOAD, 6'b0}, 0, 0, ST | DV | MTR, 15, "load_rst");
    #2;
    Reset_n = 1'b0;
    #1;
    push(ST | HD, 0, "async_rst");
    check();
    @(negedge Clk);
    Reset_n = 1'b1;
    step(1, {_ADD, 6'b0}, 0, 0, ST | HD, 0, "post_rst");
    step(0, '0, 0, 1, '0, 0, "start2");
    step(1, {_XOR, 6'b0}, 0, 0, DV | RWE, 1, "xor");
    step(1, {_SUB, 6'b0}, 0, 0, DV | RWE, 2, "sub");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Registered, parametrised control unit for the Lambo processor. It decodes the instruction word using the opcode values from `definitions`, and presents registered control strobes one cycle after fetch. It also sequences multi-cycle LOAD/STORE wait states, owns the halted/start state, and squashes the in-flight instruction on a taken-branch flush. It sits between instruction ROM/fetch and the datapath, and drives `Stall` back to the program counter.

## Interface
- `IW`, 9: instruction width (≥9); fields are fixed relative to the MSB.
- `MEM_LAT`, 2: cycles a LOAD/STORE occupies the control outputs (1..15).
- `CNT_W`, 16: width of `InstrCount`.

- `Clk`  in  1  clock. One clock domain only.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  leaves HALTED; ignored in other states.
- `InstrValid`  in  1  `Instruction` is valid this cycle.
- `Instruction`  in  IW  machine code from instruction ROM.
- `Flush`  in  1  squashes the instruction being captured this cycle.
- `Stall`  out  1  fetch must hold PC and `Instruction`.
- `DecValid`  out  1  registered decode is a live instruction.
- `Immediate`, `RegSet`, `BranchEn`, `ConditionBranch`, `Halt`, `Shift`, `RDX`, `MemToReg`, `RegWriteEn`, `MemWriteEn`  out  1 each  registered control strobes.
- `Halted`  out  1  state is HALTED.
- `InstrCount`  out  CNT_W  decoded-instruction counter (see Configuration).

## Operation
**Field decode:**
- Opcode = `Instruction[IW-1:IW-3]`.
- C = `Instruction[IW-4]`.
- F = `Instruction[IW-4:IW-6]`.
- S = OR of `Instruction[IW-6:0]`.

**Strobe equations** (all registered, and all forced to 0 when `DecValid`=0):
- `Immediate` = Opcode==_LSHIFT.
- `RegSet` = _LSHIFT & F==3'b111.
- `RDX` = _LSHIFT & F==3'b110.
- `ConditionBranch` = C.
- `BranchEn` = _BRANCH & !S.
- `Halt` = _CMP & C & S.
- `Shift` = _CMP & !C & S.
- `MemToReg` = _LOAD.
- `MemWriteEn` = _STORE, first cycle only.
- `RegWriteEn` = _XOR | _ADD | _SUB | _LSHIFT; for _LOAD, asserted in the final occupancy cycle only.

**States:** HALTED, RUN, MEMWAIT. A 4-bit wait counter `cnt` is used in MEMWAIT.

**HALTED:**
- `Stall`=1, `Halted`=1, `DecValid`=0.
- `Start`=1 → RUN at the next edge.

**RUN:** at each edge:
- If `InstrValid` & !`Flush`: capture the decode and set `DecValid`=1.
- Otherwise: set `DecValid`=0.
- Captured _LOAD/_STORE with `MEM_LAT`>1 → MEMWAIT, `cnt`=`MEM_LAT`-1.
- Captured Halt → HALTED. `Halt`=1 for exactly that one output cycle.

**MEMWAIT:**
- `Stall`=1; no capture; decode outputs held; `Flush` and `InstrValid` ignored.
- Each edge, `cnt` decrements.
- At the edge where `cnt`==1 → RUN without capture. The memory op stays on the outputs for one more cycle, with `Stall`=0.

**Boundary behaviour:**
- `Flush`=1 and a Halt instruction in the same cycle → squashed; no halt.
- `Start` in RUN/MEMWAIT → no effect.
- `Reset_n` low mid-MEMWAIT → HALTED immediately, all strobes 0. No pending write completes.
- `MEM_LAT`=1 → memory ops behave as single-cycle; MEMWAIT is never entered.

## Timing
- **Reset values:** state HALTED; `Stall`=1, `Halted`=1; every other output 0; `InstrCount`=0.
- **Latency:** `Instruction` presented in cycle n → strobes valid in cycle n+1.
- **Stall:** a Moore output of state only (no combinational path from inputs).
- **LOAD:** visible for `MEM_LAT` cycles; `Stall` high for the first `MEM_LAT`-1 of them; `RegWriteEn` high only in the last.
- **STORE:** visible for `MEM_LAT` cycles; `MemWriteEn` high only in the first.
- **After `Start`:** first capture occurs at the edge that ends the first RUN cycle.

## Configuration
- `LAMBO_CTRL_PERF_EN` defined:
  - `InstrCount` increments on every capture with `DecValid`=1; squashed and HALTED cycles are not counted.
  - Saturates at all-ones.
  - Cleared to 0 by the `Start` edge and by reset.
- `LAMBO_CTRL_PERF_EN` undefined: `InstrCount` port present, tied to 0; no counter flops.

## Test plan
- **Reset, then start:** `Reset_n` low → `Stall`=1, `Halted`=1, all strobes 0. Pulse `Start` → RUN; `{_ADD,6'b0}` → `RegWriteEn`=1, `DecValid`=1 the next cycle.
- **Load wait states:** `MEM_LAT`=3, `{_LOAD,6'b0}` → `MemToReg`=1 for 3 cycles; `Stall`=1,1,0; `RegWriteEn`=0,0,1.
- **Store:** `MEM_LAT`=3, `{_STORE,6'b0}` → `MemWriteEn`=1,0,0; `Stall`=1,1,0.
- **Flush:** `{_BRANCH,6'b000000}` gives `BranchEn`=1. Next instruction `{_ADD,…}` with `Flush`=1 → `DecValid`=0, `RegWriteEn`=0; `InstrCount` does not increment.
- **Halt and restart:** `{_CMP,6'b100001}` → `Halt`=1 for one cycle, then `Halted`=1, `Stall`=1. `Start` → RUN, and `InstrCount` clears to 0.
- **Reset mid-MEMWAIT and saturation:** async `Reset_n` mid-MEMWAIT → outputs return to reset values without waiting for a clock edge. With `LAMBO_CTRL_PERF_EN` and `CNT_W`=4, 20 ADDs → `InstrCount`=15.
